// File: rtl/display_source_scheduler_pkg.sv
// Shared definitions for the display source scheduler.
//   DISP_W  : width of one source value and of disp_num
//   IDX_W   : width of src_idx (sized for up to 8 sources)
//   state_t : MANUAL/AUTO selection state
package display_source_scheduler_pkg;

  localparam int DISP_W = 32;
  localparam int IDX_W  = 3;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_AUTO   = 1'b1
  } state_t;

endpackage

// File: rtl/display_source_scheduler_button_debounce.sv
// Push-button conditioner: 2-FF synchronizer, debounce counter and a
// one-cycle pulse on each accepted rising edge.
//   clk   : system clock, rising edge
//   rst   : synchronous reset, active-high
//   raw   : asynchronous button level
//   pulse : one-cycle strobe when the debounced level goes 0 -> 1
module display_source_scheduler_button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // The counter only runs while the synchronized sample disagrees with the
  // accepted level; any sample that falls back to the accepted level restarts
  // it, so a new level needs DEBOUNCE_CYCLES consecutive identical samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      pulse <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
        pulse <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_source_scheduler.sv
// Selects which 32-bit CPU debug value feeds the 8-digit hex display.
// Manual mode steps on a debounced button press; auto mode also steps
// every ROTATE_CYCLES clocks. Invalid sources are skipped.
//   clk         : system clock, rising edge
//   rst         : synchronous reset, active-high
//   src_bus     : NUM_SRC packed 32-bit sources, source k at [32k+31:32k]
//   src_valid   : per-source enable
//   btn_next    : raw push-button (async)
//   sw_auto     : raw mode switch, 1 = auto
//   hold        : freeze disp_num
//   disp_num    : registered value of the selected source
//   src_idx     : currently selected source
//   auto_active : high while in AUTO
module display_source_scheduler
  import display_source_scheduler_pkg::*;
#(
  parameter int NUM_SRC         = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ROTATE_CYCLES   = 50000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DISP_W*NUM_SRC-1:0] src_bus,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic                      btn_next,
  input  logic                      sw_auto,
  input  logic                      hold,
  output logic [DISP_W-1:0]         disp_num,
  output logic [IDX_W-1:0]          src_idx,
  output logic                      auto_active
);

  localparam int ROT_W = $clog2(ROTATE_CYCLES + 1);

  state_t             state;
  state_t             next_state;
  logic               sw_s1;
  logic               sw_s2;
  logic               next_pulse;
  logic [ROT_W-1:0]   rot_cnt;
  logic               rot_expire;
  logic               cur_valid;
  logic [DISP_W-1:0]  cur_slice;
  logic [IDX_W-1:0]   next_idx;
  logic               found;
  logic               advance;
  int                 cand;

  display_source_scheduler_button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_next),
    .pulse (next_pulse)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_MANUAL;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_MANUAL: if (sw_s2)  next_state = ST_AUTO;
      ST_AUTO:   if (!sw_s2) next_state = ST_MANUAL;
      default:   next_state = ST_MANUAL;
    endcase
    auto_active = (state == ST_AUTO);
    rot_expire  = auto_active && (rot_cnt == ROT_W'(ROTATE_CYCLES - 1));
  end

  // Current slice/valid bit via shifts so the 3-bit index never has to
  // address past NUM_SRC entries.
  always_comb begin
    cur_slice = DISP_W'(src_bus >> (DISP_W * int'(src_idx)));
    cur_valid = 1'(src_valid >> src_idx);
    advance   = next_pulse || rot_expire || !cur_valid;
  end

  // Cyclic search starting just after src_idx; the final candidate is
  // src_idx itself, so a lone valid source keeps its index and an empty
  // mask leaves next_idx unchanged.
  always_comb begin
    next_idx = src_idx;
    found    = 1'b0;
    cand     = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = int'(src_idx) + k;
      if (cand >= NUM_SRC) cand = cand - NUM_SRC;
      if (!found && 1'(src_valid >> cand)) begin
        next_idx = IDX_W'(cand);
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1    <= 1'b0;
      sw_s2    <= 1'b0;
      rot_cnt  <= '0;
      src_idx  <= '0;
      disp_num <= '0;
    end else begin
      sw_s1 <= sw_auto;
      sw_s2 <= sw_s1;
      // Simultaneous button and expiry collapse into the single advance term.
      if ((state != next_state) || advance) begin
        rot_cnt <= '0;
      end else if (state == ST_AUTO) begin
        rot_cnt <= rot_cnt + 1'b1;
      end
      if (advance) begin
        src_idx <= next_idx;
      end
      if (!hold) begin
        disp_num <= (|src_valid) ? cur_slice : '0;
      end
    end
  end

endmodule

// File: tb/tb_display_source_scheduler.sv
module tb_display_source_scheduler;

  localparam int NSRC = 4;
  localparam int DEB  = 4;
  localparam int ROT  = 8;

  logic             clk;
  logic             rst;
  logic [31:0]      src_val [NSRC];
  logic [32*NSRC-1:0] src_bus;
  logic [NSRC-1:0]  src_valid;
  logic             btn_next;
  logic             sw_auto;
  logic             hold;
  logic [31:0]      disp_num;
  logic [2:0]       src_idx;
  logic             auto_active;

  int tests_run;
  int tests_failed;
  int lat;

  assign src_bus = {src_val[3], src_val[2], src_val[1], src_val[0]};

  display_source_scheduler #(
    .NUM_SRC(NSRC),
    .DEBOUNCE_CYCLES(DEB),
    .ROTATE_CYCLES(ROT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .src_bus(src_bus),
    .src_valid(src_valid),
    .btn_next(btn_next),
    .sw_auto(sw_auto),
    .hold(hold),
    .disp_num(disp_num),
    .src_idx(src_idx),
    .auto_active(auto_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference rule: next index after cur with a set mask bit, cyclically;
  // cur itself is the last candidate, and no hit leaves cur unchanged.
  function automatic int next_valid(input int cur, input logic [3:0] m);
    int c;
    for (int k = 1; k <= NSRC; k++) begin
      c = (cur + k) % NSRC;
      if (((m >> c) & 4'd1) != 4'd0) return c;
    end
    return cur;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; btn_next = 1'b0; sw_auto = 1'b0; hold = 1'b0;
    src_valid = 4'hF;
    for (int k = 0; k < NSRC; k++) src_val[k] = 32'hA0 + 32'(k);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic press();
    btn_next = 1'b1;
    repeat (10) @(negedge clk);
    btn_next = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_idx_change(input int max, output int cycles, output bit ok);
    logic [2:0] start;
    start = src_idx;
    cycles = 0;
    ok = 1'b0;
    while (cycles < max && !ok) begin
      @(negedge clk);
      cycles++;
      if (src_idx !== start) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (src_idx !== 3'd0) begin tests_failed++; $display("FAIL reset_idx got %0d want 0", src_idx); end
    tests_run++;
    if (auto_active !== 1'b0) begin tests_failed++; $display("FAIL reset_auto got %0b want 0", auto_active); end
    tests_run++;
    if (disp_num !== 32'h0) begin tests_failed++; $display("FAIL reset_disp got %h want 0", disp_num); end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (disp_num !== 32'hA0) begin tests_failed++; $display("FAIL reset_first_disp got %h want a0", disp_num); end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      btn_next = ~i[0];
      @(negedge clk);
    end
    btn_next = 1'b1;
    repeat (10) @(negedge clk);
    btn_next = 1'b0;
    repeat (12) @(negedge clk);
    tests_run++;
    if (src_idx !== 3'd1) begin tests_failed++; $display("FAIL bounce_idx got %0d want 1", src_idx); end
    tests_run++;
    if (disp_num !== 32'hA1) begin tests_failed++; $display("FAIL bounce_disp got %h want a1", disp_num); end
  endtask

  task automatic test_auto_rotate();
    int cyc;
    bit ok;
    int exp;
    do_reset();
    sw_auto = 1'b1;
    cyc = 0;
    while (auto_active !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
    tests_run++;
    if (auto_active !== 1'b1) begin tests_failed++; $display("FAIL auto_enter got %0b want 1", auto_active); end
    exp = 0;
    for (int n = 0; n < 4; n++) begin
      exp = next_valid(exp, 4'hF);
      wait_idx_change(20, cyc, ok);
      tests_run++;
      if (!ok || src_idx !== 3'(exp)) begin
        tests_failed++; $display("FAIL auto_step%0d got %0d want %0d", n, src_idx, exp);
      end
      tests_run++;
      if (cyc != ROT) begin tests_failed++; $display("FAIL auto_period%0d got %0d want %0d", n, cyc, ROT); end
    end
    sw_auto = 1'b0;
  endtask

  task automatic test_valid_mask();
    do_reset();
    @(negedge clk);
    src_valid = 4'b1010;
    @(negedge clk);
    tests_run++;
    if (src_idx !== 3'd1) begin tests_failed++; $display("FAIL mask_invalid_skip got %0d want 1", src_idx); end
    press();
    tests_run++;
    if (src_idx !== 3'd3) begin tests_failed++; $display("FAIL mask_press1 got %0d want 3", src_idx); end
    press();
    tests_run++;
    if (src_idx !== 3'd1) begin tests_failed++; $display("FAIL mask_press2 got %0d want 1", src_idx); end
    src_valid = 4'b0000;
    repeat (3) @(negedge clk);
    tests_run++;
    if (disp_num !== 32'h0) begin tests_failed++; $display("FAIL mask_empty_disp got %h want 0", disp_num); end
    tests_run++;
    if (src_idx !== 3'd1) begin tests_failed++; $display("FAIL mask_empty_idx got %0d want 1", src_idx); end
  endtask

  task automatic test_hold();
    int cyc;
    do_reset();
    sw_auto = 1'b1;
    cyc = 0;
    while (disp_num !== 32'hA2 && cyc < 60) begin @(negedge clk); cyc++; end
    tests_run++;
    if (disp_num !== 32'hA2) begin tests_failed++; $display("FAIL hold_reach got %h want a2", disp_num); end
    hold = 1'b1;
    cyc = 0;
    while (src_idx !== 3'd0 && cyc < 30) begin @(negedge clk); cyc++; end
    tests_run++;
    if (src_idx !== 3'd0) begin tests_failed++; $display("FAIL hold_idx got %0d want 0", src_idx); end
    tests_run++;
    if (disp_num !== 32'hA2) begin tests_failed++; $display("FAIL hold_disp got %h want a2", disp_num); end
    hold = 1'b0;
    @(negedge clk);
    tests_run++;
    if (disp_num !== 32'hA0) begin tests_failed++; $display("FAIL hold_release got %h want a0", disp_num); end
    sw_auto = 1'b0;
  endtask

  task automatic test_simultaneous();
    int cyc;
    bit ok;
    int prev;
    bit bad;
    do_reset();
    @(negedge clk);
    btn_next = 1'b1;
    wait_idx_change(20, lat, ok);
    btn_next = 1'b0;
    repeat (12) @(negedge clk);
    tests_run++;
    if (!ok || lat < DEB + 2 || lat > ROT) begin
      tests_failed++; $display("FAIL press_latency got %0d want %0d..%0d", lat, DEB + 2, ROT);
    end else begin
      sw_auto = 1'b1;
      wait_idx_change(30, cyc, ok);
      repeat (ROT - lat) @(negedge clk);
      btn_next = 1'b1;
      prev = int'(src_idx);
      repeat (lat) @(negedge clk);
      tests_run++;
      if (src_idx !== 3'(next_valid(prev, 4'hF))) begin
        tests_failed++; $display("FAIL sim_single_step got %0d want %0d", src_idx, next_valid(prev, 4'hF));
      end
      btn_next = 1'b0;
      prev = int'(src_idx);
      wait_idx_change(20, cyc, ok);
      tests_run++;
      if (!ok || cyc != ROT || src_idx !== 3'(next_valid(prev, 4'hF))) begin
        tests_failed++; $display("FAIL sim_next_dwell got %0d cycles idx %0d want %0d idx %0d",
                                 cyc, src_idx, ROT, next_valid(prev, 4'hF));
      end
    end
    sw_auto = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (src_idx !== 3'd0 || auto_active !== 1'b0) begin
      tests_failed++; $display("FAIL midreset_state got idx %0d auto %0b want 0 0", src_idx, auto_active);
    end
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (src_idx !== 3'd0) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin tests_failed++; $display("FAIL midreset_early_step got idx %0d want 0", src_idx); end
    @(negedge clk);
    tests_run++;
    if (src_idx !== 3'd1) begin tests_failed++; $display("FAIL midreset_first_step got %0d want 1", src_idx); end
    sw_auto = 1'b0;
  endtask

  task automatic test_random();
    int exp;
    logic [3:0] m;
    do_reset();
    repeat (3) @(negedge clk);
    exp = 0;
    for (int it = 0; it < 12; it++) begin
      for (int k = 0; k < NSRC; k++) src_val[k] = $urandom;
      m = 4'($urandom_range(1, 15));
      src_valid = m;
      if (((m >> exp) & 4'd1) == 4'd0) exp = next_valid(exp, m);
      repeat (2) @(negedge clk);
      tests_run++;
      if (src_idx !== 3'(exp)) begin tests_failed++; $display("FAIL rnd_mask%0d got %0d want %0d", it, src_idx, exp); end
      tests_run++;
      if (disp_num !== src_val[exp]) begin
        tests_failed++; $display("FAIL rnd_disp%0d got %h want %h", it, disp_num, src_val[exp]);
      end
      src_val[exp] = $urandom;
      @(negedge clk);
      tests_run++;
      if (disp_num !== src_val[exp]) begin
        tests_failed++; $display("FAIL rnd_latency%0d got %h want %h", it, disp_num, src_val[exp]);
      end
      press();
      exp = next_valid(exp, m);
      tests_run++;
      if (src_idx !== 3'(exp)) begin tests_failed++; $display("FAIL rnd_press%0d got %0d want %0d", it, src_idx, exp); end
      tests_run++;
      if (disp_num !== src_val[exp]) begin
        tests_failed++; $display("FAIL rnd_press_disp%0d got %h want %h", it, disp_num, src_val[exp]);
      end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    lat = 0;
    rst = 1'b1;
    btn_next = 1'b0;
    sw_auto = 1'b0;
    hold = 1'b0;
    src_valid = 4'hF;
    for (int k = 0; k < NSRC; k++) src_val[k] = 32'hA0 + 32'(k);
    test_reset();
    test_bounce();
    test_auto_rotate();
    test_valid_mask();
    test_hold();
    test_simultaneous();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
